// File: rtl/tdoa_capture_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdoa_capture_sequencer_if
// Purpose  : Correlator control and result handshake bundle for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface tdoa_capture_sequencer_if;
  logic        enable;
  logic        corr_done;
  logic [7:0]  corr_offset_1;
  logic [7:0]  corr_offset_2;
  logic        corr_reset;
  logic        result_valid;
  logic        result_ready;
  logic [7:0]  result_offset_1;
  logic [7:0]  result_offset_2;
  logic        busy;
  logic        timeout_flag;
  logic [15:0] capture_count;

  modport master (
    input  enable, corr_done, corr_offset_1, corr_offset_2, result_ready,
    output corr_reset, result_valid, result_offset_1, result_offset_2,
           busy, timeout_flag, capture_count
  );

  modport slave (
    output enable, corr_done, corr_offset_1, corr_offset_2, result_ready,
    input  corr_reset, result_valid, result_offset_1, result_offset_2,
           busy, timeout_flag, capture_count
  );
endinterface
`default_nettype wire

// File: rtl/tdoa_capture_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdoa_capture_sequencer
// Purpose  : Arms the TDOA correlator, latches its offsets and hands them to a
//            consumer; optional LISTEN timeout under TDOA_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdoa_capture_sequencer #(
  parameter int unsigned ARM_CYCLES     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 24
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  tdoa_capture_sequencer_if.master       seq_io
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_LISTEN  = 3'd2,
    S_LATCH   = 3'd3,
    S_REPORT  = 3'd4,
    S_HOLDOFF = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LSN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE    = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             corr_reset_q;
  logic             valid_q;
  logic             busy_q;
  logic [7:0]       off1_q, off2_q;
  logic [15:0]      count_q;

  logic             w_done_ok;
  logic             w_handshake;

  // The first two LISTEN cycles may still show done from the previous run.
  assign w_done_ok   = seq_io.corr_done && (cnt_q >= C_SETTLE);
  assign w_handshake = (state_q == S_REPORT) && valid_q && seq_io.result_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + C_CNT_ONE;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (seq_io.enable) begin
          state_d   = S_ARM;
          timeout_d = 1'b0;
        end
      end
      S_ARM: begin
        if (!seq_io.enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == C_ARM_LAST) begin
          state_d = S_LISTEN;
        end
      end
      S_LISTEN: begin
        if (!seq_io.enable) begin
          state_d = S_IDLE;
        end else if (w_done_ok) begin
          state_d = S_LATCH;
        end else if (cnt_q == C_LSN_LAST) begin
`ifdef TDOA_SEQ_TIMEOUT_EN
          state_d   = S_HOLDOFF;
          timeout_d = 1'b1;
`else
          // Saturate so a very long wait never re-enters the settle window.
          cnt_d = cnt_q;
`endif
        end
      end
      S_LATCH: begin
        state_d = S_REPORT;
      end
      S_REPORT: begin
        cnt_d = cnt_q;
        if (w_handshake) begin
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == C_HOLD_LAST) begin
          if (seq_io.enable) begin
            state_d   = S_ARM;
            timeout_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      corr_reset_q <= 1'b1;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      off1_q       <= 8'h00;
      off2_q       <= 8'h00;
      count_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      // Outputs are decoded from the next state so they line up with it.
      corr_reset_q <= !((state_d == S_LISTEN) || (state_d == S_LATCH) ||
                        (state_d == S_REPORT));
      valid_q      <= (state_d == S_REPORT);
      busy_q       <= (state_d != S_IDLE);
      if (state_q == S_LATCH) begin
        off1_q <= seq_io.corr_offset_1;
        off2_q <= seq_io.corr_offset_2;
      end
      if (w_handshake) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign seq_io.corr_reset      = corr_reset_q;
  assign seq_io.result_valid    = valid_q;
  assign seq_io.result_offset_1 = off1_q;
  assign seq_io.result_offset_2 = off2_q;
  assign seq_io.busy            = busy_q;
  assign seq_io.timeout_flag    = timeout_q;
  assign seq_io.capture_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_tdoa_capture_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for tdoa_capture_sequencer: cycle table for the main flow plus
// hand-written timeout and asynchronous-reset sequences.
module tb_tdoa_capture_sequencer;
  localparam int ARM  = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdoa_capture_sequencer_if bus ();

  tdoa_capture_sequencer #(
    .ARM_CYCLES     (ARM),
    .HOLDOFF_CYCLES (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (24)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus)
  );

  typedef struct {
    logic        en;
    logic        done;
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic        rdy;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  localparam logic [35:0] RESET_VEC = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0};

  // {corr_reset, valid, off1, off2, busy, count, timeout_flag}
  function automatic logic [35:0] obs();
    return {bus.corr_reset, bus.result_valid, bus.result_offset_1, bus.result_offset_2,
            bus.busy, bus.capture_count, bus.timeout_flag};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic en, input logic dn,
                              input logic [7:0] o1, input logic [7:0] o2, input logic rdy,
                              input logic cr, input logic v, input logic [7:0] r1,
                              input logic [7:0] r2, input logic bz, input logic [15:0] cnt);
    vec_t r;
    r.en = en; r.done = dn; r.o1 = o1; r.o2 = o2; r.rdy = rdy;
    r.exp = {cr, v, r1, r2, bz, cnt, 1'b0};
    for (int k = 0; k < n; k++) vecs.push_back(r);
  endfunction

  int n;

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.corr_done = 1'b0; bus.result_ready = 1'b0;
    bus.corr_offset_1 = 8'h00; bus.corr_offset_2 = 8'h00;

    // Capture 1: done on LISTEN cycle 10, immediate accept, then stop.
    add(1, 1,0,8'hAA,8'hBB,0, 1,0,8'h00,8'h00,0,16'd0);
    add(4, 1,0,8'hAA,8'hBB,0, 1,0,8'h00,8'h00,1,16'd0);
    add(9, 1,0,8'hAA,8'hBB,0, 0,0,8'h00,8'h00,1,16'd0);
    add(1, 1,1,8'h12,8'h34,0, 0,0,8'h00,8'h00,1,16'd0);
    add(1, 1,0,8'h12,8'h34,1, 0,0,8'h00,8'h00,1,16'd0);
    add(1, 1,0,8'hAA,8'hBB,1, 0,1,8'h12,8'h34,1,16'd0);
    add(7, 1,0,8'hAA,8'hBB,0, 1,0,8'h12,8'h34,1,16'd1);
    add(1, 0,0,8'hAA,8'hBB,0, 1,0,8'h12,8'h34,1,16'd1);
    // Capture 2: stale done, enable drop in LATCH, consumer stalls 50 cycles.
    add(1, 1,0,8'hAA,8'hBB,0, 1,0,8'h12,8'h34,0,16'd1);
    add(4, 1,0,8'hAA,8'hBB,0, 1,0,8'h12,8'h34,1,16'd1);
    add(2, 1,1,8'hAA,8'hBB,1, 0,0,8'h12,8'h34,1,16'd1);
    add(4, 1,0,8'hAA,8'hBB,1, 0,0,8'h12,8'h34,1,16'd1);
    add(1, 1,1,8'h56,8'h78,0, 0,0,8'h12,8'h34,1,16'd1);
    add(1, 0,0,8'h56,8'h78,0, 0,0,8'h12,8'h34,1,16'd1);
    add(50,0,0,8'h00,8'h00,0, 0,1,8'h56,8'h78,1,16'd1);
    add(1, 0,0,8'h00,8'h00,1, 0,1,8'h56,8'h78,1,16'd1);
    add(8, 0,0,8'h00,8'h00,0, 1,0,8'h56,8'h78,1,16'd2);
    // Capture 3: enable and done drop/rise together in LISTEN -> abort.
    add(1, 1,0,8'h00,8'h00,0, 1,0,8'h56,8'h78,0,16'd2);
    add(4, 1,0,8'h00,8'h00,0, 1,0,8'h56,8'h78,1,16'd2);
    add(3, 1,0,8'h00,8'h00,0, 0,0,8'h56,8'h78,1,16'd2);
    add(1, 0,1,8'h00,8'h00,0, 0,0,8'h56,8'h78,1,16'd2);
    add(2, 0,0,8'h00,8'h00,0, 1,0,8'h56,8'h78,0,16'd2);

    repeat (2) @(negedge clk);
    chk("reset_state", 64'(obs()), 64'(RESET_VEC));
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.enable        = vecs[i].en;
      bus.corr_done     = vecs[i].done;
      bus.corr_offset_1 = vecs[i].o1;
      bus.corr_offset_2 = vecs[i].o2;
      bus.result_ready  = vecs[i].rdy;
      chk($sformatf("row%0d", i), 64'(obs()), 64'(vecs[i].exp));
      @(negedge clk);
    end

    // LISTEN with no done: timeout (if built in) or indefinite wait.
    bus.enable = 1'b1; bus.corr_done = 1'b0; bus.result_ready = 1'b0;
    n = 0;
    while (bus.corr_reset && n < 20) begin @(negedge clk); n++; end
    chk("arm_to_listen", 64'(n), 64'(ARM + 1));
    n = 0;
    while (!bus.corr_reset && n < TMO + 50) begin @(negedge clk); n++; end
`ifdef TDOA_SEQ_TIMEOUT_EN
    chk("timeout_len", 64'(n), 64'(TMO));
    chk("timeout_flag_set", 64'(bus.timeout_flag), 64'd1);
    chk("timeout_busy", 64'(bus.busy), 64'd1);
    chk("timeout_no_result", 64'({bus.result_valid, bus.capture_count}), 64'({1'b0, 16'd2}));
    repeat (HOLD - 1) @(negedge clk);
    chk("flag_sticky_holdoff", 64'({bus.timeout_flag, bus.corr_reset}), 64'({1'b1, 1'b1}));
    @(negedge clk);
    chk("flag_clear_on_arm", 64'({bus.timeout_flag, bus.corr_reset, bus.busy}), 64'({1'b0, 1'b1, 1'b1}));
`else
    chk("no_timeout_wait", 64'(n), 64'(TMO + 50));
    chk("no_timeout_flag", 64'({bus.timeout_flag, bus.corr_reset, bus.busy}), 64'({1'b0, 1'b0, 1'b1}));
`endif
    bus.enable = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    chk("abort_to_idle", 64'({bus.busy, bus.corr_reset, bus.result_valid}), 64'({1'b0, 1'b1, 1'b0}));

    // Asynchronous reset while a result is pending.
    bus.enable = 1'b1; bus.corr_done = 1'b1;
    bus.corr_offset_1 = 8'h9A; bus.corr_offset_2 = 8'hBC;
    n = 0;
    while (!bus.result_valid && n < 40) begin @(negedge clk); n++; end
    chk("reach_report", 64'({bus.result_valid, bus.result_offset_1, bus.result_offset_2}),
        64'({1'b1, 8'h9A, 8'hBC}));
    #2 rst = 1'b1;
    #1 chk("async_reset", 64'(obs()), 64'(RESET_VEC));
    bus.enable = 1'b0; bus.corr_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'(obs()), 64'(RESET_VEC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
